// File: rtl/choose_pkg.sv
// Shared types and grid helpers for the two-player choose-scene cursor controller.
package choose_pkg;

  localparam int GRID_COLS = 4;
  localparam int GRID_ROWS = 2;
  localparam int POKE_MIN  = 1;
  localparam int POKE_MAX  = 8;

  typedef enum logic [1:0] {
    S_P1   = 2'd0,
    S_P2   = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    REQ_NONE    = 3'd0,
    REQ_UP      = 3'd1,
    REQ_DOWN    = 3'd2,
    REQ_LEFT    = 3'd3,
    REQ_RIGHT   = 3'd4,
    REQ_CONFIRM = 3'd5,
    REQ_RESTART = 3'd6
  } req_e;

  // Press bits: [0] up, [1] down, [2] left, [3] right, [4] confirm, [5] restart.
  function automatic req_e pick_req(input logic [5:0] press);
    req_e r;
    if (press[5])      r = REQ_RESTART;
    else if (press[4]) r = REQ_CONFIRM;
    else if (press[0]) r = REQ_UP;
    else if (press[1]) r = REQ_DOWN;
    else if (press[2]) r = REQ_LEFT;
    else if (press[3]) r = REQ_RIGHT;
    else               r = REQ_NONE;
    return r;
  endfunction

  function automatic logic [2:0] grid_move(input logic [2:0] idx, input req_e r);
    int row;
    int col;
    row = int'(idx) / GRID_COLS;
    col = int'(idx) % GRID_COLS;
    case (r)
      REQ_LEFT:  col = (col + GRID_COLS - 1) % GRID_COLS;
      REQ_RIGHT: col = (col + 1) % GRID_COLS;
      REQ_UP:    row = (row + GRID_ROWS - 1) % GRID_ROWS;
      REQ_DOWN:  row = (row + 1) % GRID_ROWS;
      default: ;
    endcase
    return 3'(row * GRID_COLS + col);
  endfunction

endpackage

// File: rtl/btn_edge_pulse.sv
// Two-flop synchroniser plus registered rising-edge detect: one pulse per press,
// three clocks after the raw rise.
module btn_edge_pulse (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic pulse_o
);

  logic s1_q, s2_q, s3_q, pulse_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      s1_q    <= btn_i;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      pulse_q <= s2_q & ~s3_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/choose_cursor_ctrl.sv
// Cursor and two-player pick controller for the choose scene; all visible
// changes are deferred to the frame tick so the highlight is stable per frame.
module choose_cursor_ctrl
  import choose_pkg::*;
#(
  parameter int ID_W      = 8,
  parameter int TICK_LINE = 480
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [9:0]      h_cnt,
  input  logic [9:0]      v_cnt,
  input  logic            btn_up,
  input  logic            btn_down,
  input  logic            btn_left,
  input  logic            btn_right,
  input  logic            btn_confirm,
  input  logic            btn_restart,
  output logic [ID_W-1:0] pokemon_id,
  output logic [ID_W-1:0] p1_id,
  output logic [ID_W-1:0] p2_id,
  output logic            turn,
  output logic            choose_done
);

  logic [5:0]      press_s;
  logic [5:0]      raw_s;
  logic            tick_s;
  logic            cursor_ok_s;
  logic [2:0]      idx_s;
  logic [3:0]      moved_s;
  req_e            new_req_s;
  req_e            pend_q, pend_d;
  state_e          state_q, state_d;
  logic [ID_W-1:0] cursor_q, cursor_d;
  logic [ID_W-1:0] p1_q, p1_d;
  logic [ID_W-1:0] p2_q, p2_d;
  logic            turn_q, turn_d;
  logic            done_q, done_d;

  assign raw_s = {btn_restart, btn_confirm, btn_right, btn_left, btn_down, btn_up};

  for (genvar g = 0; g < 6; g++) begin : g_btn
    btn_edge_pulse u_btn (
      .clk     (clk),
      .rst     (rst),
      .btn_i   (raw_s[g]),
      .pulse_o (press_s[g])
    );
  end

  assign new_req_s   = pick_req(press_s);
  assign tick_s      = (v_cnt == 10'(TICK_LINE)) && (h_cnt == 10'd0);
  assign cursor_ok_s = (cursor_q >= ID_W'(POKE_MIN)) && (cursor_q <= ID_W'(POKE_MAX));
  assign idx_s       = cursor_q[2:0] - 3'd1;
  assign moved_s     = {1'b0, grid_move(idx_s, pend_q)} + 4'd1;

  // The tick slot refills from a same-cycle press; otherwise only an empty slot captures.
  always_comb begin
    pend_d = pend_q;
    if (tick_s) begin
      pend_d = new_req_s;
    end else if (pend_q == REQ_NONE) begin
      pend_d = new_req_s;
    end else begin
      pend_d = pend_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_P1;
      pend_q   <= REQ_NONE;
      cursor_q <= ID_W'(POKE_MIN);
      p1_q     <= '0;
      p2_q     <= '0;
      turn_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      cursor_q <= cursor_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      turn_q   <= turn_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (tick_s) begin
      if (pend_q == REQ_RESTART) begin
        state_d = S_P1;
      end else if (pend_q == REQ_CONFIRM && cursor_ok_s) begin
        case (state_q)
          S_P1:    state_d = S_P2;
          S_P2:    state_d = (cursor_q != p1_q) ? S_DONE : S_P2;
          S_DONE:  state_d = S_DONE;
          default: state_d = S_P1;
        endcase
      end else begin
        state_d = (state_q == S_P1 || state_q == S_P2 || state_q == S_DONE) ? state_q : S_P1;
      end
    end else begin
      state_d = state_q;
    end
  end

  // Datapath: a forced out-of-range cursor recovers to 1 and swallows that tick's request.
  always_comb begin
    cursor_d = cursor_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    if (tick_s) begin
      if (pend_q == REQ_RESTART) begin
        cursor_d = ID_W'(POKE_MIN);
        p1_d     = '0;
        p2_d     = '0;
      end else if (!cursor_ok_s) begin
        cursor_d = ID_W'(POKE_MIN);
      end else begin
        case (pend_q)
          REQ_CONFIRM: begin
            if (state_q == S_P1) p1_d = cursor_q;
            else if (state_q == S_P2 && cursor_q != p1_q) p2_d = cursor_q;
            else p1_d = p1_q;
          end
          REQ_UP, REQ_DOWN, REQ_LEFT, REQ_RIGHT: begin
            if (state_q != S_DONE) cursor_d = {{(ID_W-4){1'b0}}, moved_s};
            else cursor_d = cursor_q;
          end
          default: ;
        endcase
      end
    end else begin
      cursor_d = cursor_q;
    end
  end

  always_comb begin
    turn_d = 1'b0;
    done_d = 1'b0;
    case (state_d)
      S_P1:    turn_d = 1'b0;
      S_P2:    turn_d = 1'b1;
      S_DONE: begin
        turn_d = 1'b1;
        done_d = 1'b1;
      end
      default: turn_d = 1'b0;
    endcase
  end

  assign pokemon_id  = cursor_q;
  assign p1_id       = p1_q;
  assign p2_id       = p2_q;
  assign turn        = turn_q;
  assign choose_done = done_q;

endmodule

// File: tb/tb_choose_cursor_ctrl.sv
// Bench for choose_cursor_ctrl: directed frame table, hand sequences, and a
// random run against a frame-level reference model.
module tb_choose_cursor_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] h_cnt = 10'd0;
  logic [9:0] v_cnt = 10'd0;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0;
  logic       btn_right = 1'b0, btn_confirm = 1'b0, btn_restart = 1'b0;
  logic [7:0] pokemon_id, p1_id, p2_id;
  logic       turn, choose_done;

  int n_tests = 0;
  int n_fail  = 0;

  choose_cursor_ctrl dut (
    .clk(clk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .btn_confirm(btn_confirm), .btn_restart(btn_restart),
    .pokemon_id(pokemon_id), .p1_id(p1_id), .p2_id(p2_id),
    .turn(turn), .choose_done(choose_done)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] B_UP = 6'b000001, B_DN = 6'b000010, B_LF = 6'b000100;
  localparam logic [5:0] B_RT = 6'b001000, B_CF = 6'b010000, B_RS = 6'b100000;
  localparam logic [5:0] B_NO = 6'b000000;

  // Reference model: picks, phase 0/1/2, one-slot pending, press latency line.
  int         m_id, m_p1, m_p2, m_phase, m_pend;
  logic [5:0] m_prev;
  logic [5:0] m_dl [3];

  task automatic model_reset();
    m_id = 1; m_p1 = 0; m_p2 = 0; m_phase = 0; m_pend = 0;
    m_prev = 6'd0;
    for (int i = 0; i < 3; i++) m_dl[i] = 6'd0;
  endtask

  function automatic int prio(input logic [5:0] m);
    if (m[5]) return 6;
    if (m[4]) return 5;
    if (m[0]) return 1;
    if (m[1]) return 2;
    if (m[2]) return 3;
    if (m[3]) return 4;
    return 0;
  endfunction

  task automatic model_apply(input int req);
    int row, col;
    row = (m_id - 1) / 4;
    col = (m_id - 1) % 4;
    case (req)
      6: begin m_id = 1; m_p1 = 0; m_p2 = 0; m_phase = 0; end
      5: begin
        if (m_phase == 0) begin m_p1 = m_id; m_phase = 1; end
        else if (m_phase == 1 && m_id != m_p1) begin m_p2 = m_id; m_phase = 2; end
      end
      1, 2, 3, 4: if (m_phase != 2) begin
        if (req == 1) row = (row + 1) % 2;
        if (req == 2) row = (row + 1) % 2;
        if (req == 3) col = (col + 3) % 4;
        if (req == 4) col = (col + 1) % 4;
        m_id = row * 4 + col + 1;
      end
      default: ;
    endcase
  endtask

  task automatic model_edge(input logic [5:0] raw, input bit tick);
    logic [5:0] rise, pm;
    int req;
    rise = raw & ~m_prev;
    m_prev = raw;
    pm = m_dl[2];
    m_dl[2] = m_dl[1];
    m_dl[1] = m_dl[0];
    m_dl[0] = rise;
    req = prio(pm);
    if (tick) begin
      model_apply(m_pend);
      m_pend = req;
    end else if (m_pend == 0) begin
      m_pend = req;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    check("model.pokemon_id", int'(pokemon_id), m_id);
    check("model.p1_id", int'(p1_id), m_p1);
    check("model.p2_id", int'(p2_id), m_p2);
    check("model.turn", int'(turn), (m_phase != 0) ? 1 : 0);
    check("model.choose_done", int'(choose_done), (m_phase == 2) ? 1 : 0);
  endtask

  // One clock: drive inputs, take the edge, advance the model, compare.
  task automatic step(input logic [5:0] raw, input bit tick, input bit rnd);
    {btn_restart, btn_confirm, btn_right, btn_left, btn_down, btn_up} = raw;
    if (tick) begin
      v_cnt = 10'd480; h_cnt = 10'd0;
    end else if (!rnd) begin
      v_cnt = 10'd100; h_cnt = 10'(n_tests % 800);
    end else if ($urandom_range(0, 3) == 0) begin
      v_cnt = 10'd480; h_cnt = 10'($urandom_range(1, 799));
    end else begin
      v_cnt = 10'($urandom_range(0, 479)); h_cnt = 10'($urandom_range(0, 799));
    end
    @(posedge clk);
    model_edge(raw, tick);
    #1;
    cmp_model();
  endtask

  task automatic frame(input logic [5:0] b);
    repeat (4) step(b, 1'b0, 1'b0);
    repeat (3) step(B_NO, 1'b0, 1'b0);
    step(B_NO, 1'b1, 1'b0);
  endtask

  task automatic do_async_rst();
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    check("async_rst.pokemon_id", int'(pokemon_id), 1);
    check("async_rst.p1_id", int'(p1_id), 0);
    check("async_rst.turn", int'(turn), 0);
    cmp_model();
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic [5:0] btn;
    int         id;
    int         p1;
    int         p2;
    int         trn;
    int         dn;
  } vec_t;

  vec_t vecs [18];
  logic [5:0] cur_raw;
  bit         tk;

  initial begin
    vecs[0]  = '{B_NO, 1, 0, 0, 0, 0};
    vecs[1]  = '{B_NO, 1, 0, 0, 0, 0};
    vecs[2]  = '{B_RT, 2, 0, 0, 0, 0};
    vecs[3]  = '{B_RT, 3, 0, 0, 0, 0};
    vecs[4]  = '{B_RT, 4, 0, 0, 0, 0};
    vecs[5]  = '{B_RT, 1, 0, 0, 0, 0};
    vecs[6]  = '{B_DN, 5, 0, 0, 0, 0};
    vecs[7]  = '{B_LF, 8, 0, 0, 0, 0};
    vecs[8]  = '{B_UP, 4, 0, 0, 0, 0};
    vecs[9]  = '{B_LF, 3, 0, 0, 0, 0};
    vecs[10] = '{B_CF, 3, 3, 0, 1, 0};
    vecs[11] = '{B_CF, 3, 3, 0, 1, 0};
    vecs[12] = '{B_RT, 4, 3, 0, 1, 0};
    vecs[13] = '{B_CF, 4, 3, 4, 1, 1};
    vecs[14] = '{B_RT, 4, 3, 4, 1, 1};
    vecs[15] = '{B_CF, 4, 3, 4, 1, 1};
    vecs[16] = '{B_RS, 1, 0, 0, 0, 0};
    vecs[17] = '{B_DN, 5, 0, 0, 0, 0};

    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.pokemon_id", int'(pokemon_id), 1);
    check("reset.choose_done", int'(choose_done), 0);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      frame(vecs[i].btn);
      check($sformatf("vec%0d.pokemon_id", i), int'(pokemon_id), vecs[i].id);
      check($sformatf("vec%0d.p1_id", i), int'(p1_id), vecs[i].p1);
      check($sformatf("vec%0d.p2_id", i), int'(p2_id), vecs[i].p2);
      check($sformatf("vec%0d.turn", i), int'(turn), vecs[i].trn);
      check($sformatf("vec%0d.done", i), int'(choose_done), vecs[i].dn);
    end

    // Mid-frame press waits for the tick; a second press in that frame is lost.
    frame(B_RS);
    repeat (4) step(B_RT, 1'b0, 1'b0);
    repeat (4) step(B_NO, 1'b0, 1'b0);
    check("midframe.hold", int'(pokemon_id), 1);
    step(B_NO, 1'b1, 1'b0);
    check("midframe.tick", int'(pokemon_id), 2);
    repeat (4) step(B_RT, 1'b0, 1'b0);
    repeat (2) step(B_NO, 1'b0, 1'b0);
    repeat (4) step(B_RT, 1'b0, 1'b0);
    repeat (3) step(B_NO, 1'b0, 1'b0);
    step(B_NO, 1'b1, 1'b0);
    check("dup_press.first", int'(pokemon_id), 3);
    step(B_NO, 1'b0, 1'b0);
    step(B_NO, 1'b1, 1'b0);
    check("dup_press.dropped", int'(pokemon_id), 3);

    // Async reset with a right pending: no move on the following tick.
    repeat (4) step(B_RT, 1'b0, 1'b0);
    step(B_NO, 1'b0, 1'b0);
    do_async_rst();
    repeat (5) step(B_NO, 1'b0, 1'b0);
    step(B_NO, 1'b1, 1'b0);
    check("rst_pending.no_move", int'(pokemon_id), 1);

    cur_raw = B_NO;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        case ($urandom_range(0, 9))
          0, 1, 2: cur_raw = B_NO;
          3:       cur_raw = 6'($urandom_range(0, 31));
          4:       cur_raw = ($urandom_range(0, 3) == 0) ? B_RS : B_CF;
          default: cur_raw = 6'(1 << $urandom_range(0, 3));
        endcase
      end
      tk = ($urandom_range(0, 5) == 0);
      step(cur_raw, tk, 1'b1);
      if (i % 997 == 500) do_async_rst();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
